// File: rtl/kf_post_state_mac.sv
// rtl/kf_post_state_mac.sv - Kalman measurement update x_post = x_prior + K*(z_meas - z_hat) on one shared MAC
// KF_POST_ROUND_EN selects round-half-up instead of truncation; FXP_N / FXP_FRAC override the word format.
`ifndef FXP_N
`define FXP_N 32
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 16
`endif

module kf_post_state_mac #(
    parameter int N    = `FXP_N,
    parameter int FRAC = `FXP_FRAC,
    parameter int NX   = 4,
    parameter int NZ   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NX*N-1:0]    x_prior,
    input  logic [NZ*N-1:0]    z_meas,
    input  logic [NZ*N-1:0]    z_hat,
    input  logic [NX*NZ*N-1:0] k,
    output logic               busy,
    output logic               done,
    output logic [NX*N-1:0]    x_post,
    output logic               sat_flag
);
    localparam int IW    = (NX > 1) ? $clog2(NX) : 1;
    localparam int JW    = (NZ > 1) ? $clog2(NZ) : 1;
    localparam int ACC_W = 2*N + $clog2(NZ) + 1;
    localparam int SW    = ACC_W + 1;
    localparam logic [IW-1:0] I_LAST = IW'(NX-1);
    localparam logic [JW-1:0] J_LAST = JW'(NZ-1);
    localparam logic signed [N-1:0]  W_MAX   = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0]  W_MIN   = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [SW-1:0] SUM_MAX = {{(SW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [SW-1:0] SUM_MIN = {{(SW-N+1){1'b1}}, {(N-1){1'b0}}};
`ifdef KF_POST_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC-1);
`else
    localparam logic signed [ACC_W-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_INNOV, S_MAC, S_DONE} state_t;

    state_t state, state_nxt;
    logic [IW-1:0] cnt_i;
    logic [JW-1:0] cnt_j;
    logic          i_last, j_last, accept;

    logic signed [N-1:0] x_s   [NX];
    logic signed [N-1:0] zm_s  [NZ];
    logic signed [N-1:0] zh_s  [NZ];
    logic signed [N-1:0] k_s   [NX][NZ];
    logic signed [N-1:0] y_r   [NZ];
    logic signed [N-1:0] res_r [NX];
    logic signed [ACC_W-1:0] acc;
    logic                    sat_st;

    logic signed [N:0]       diff;
    logic signed [N-1:0]     y_sat;
    logic                    y_ovf;
    logic signed [2*N-1:0]   kx, yx, prod;
    logic signed [ACC_W-1:0] acc_nxt, acc_rnd, r;
    logic signed [SW-1:0]    sum;
    logic signed [N-1:0]     sum_sat;
    logic                    sum_ovf;

    assign i_last = (cnt_i == I_LAST);
    assign j_last = (cnt_j == J_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_INNOV;
            S_INNOV: if (j_last) state_nxt = S_MAC;
            S_MAC:   if (j_last && i_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // busy stays up through the done cycle; a start in that cycle is still taken because the FSM is already idle
    always_comb begin
        busy   = (state != S_IDLE) || done;
        accept = (state == S_IDLE) && start;
    end

    always_comb begin
        diff    = {zm_s[cnt_j][N-1], zm_s[cnt_j]} - {zh_s[cnt_j][N-1], zh_s[cnt_j]};
        y_ovf   = diff[N] ^ diff[N-1];
        y_sat   = y_ovf ? (diff[N] ? W_MIN : W_MAX) : diff[N-1:0];
        kx      = {{N{k_s[cnt_i][cnt_j][N-1]}}, k_s[cnt_i][cnt_j]};
        yx      = {{N{y_r[cnt_j][N-1]}}, y_r[cnt_j]};
        prod    = kx * yx;
        acc_nxt = ((cnt_j == '0) ? '0 : acc) + {{(ACC_W-2*N){prod[2*N-1]}}, prod};
        acc_rnd = acc_nxt + RND;
        r       = acc_rnd >>> FRAC;
        sum     = {{(SW-N){x_s[cnt_i][N-1]}}, x_s[cnt_i]} + {r[ACC_W-1], r};
        sum_ovf = (sum > SUM_MAX) || (sum < SUM_MIN);
        sum_sat = (sum > SUM_MAX) ? W_MAX : ((sum < SUM_MIN) ? W_MIN : sum[N-1:0]);
    end

    // shadow copies decouple the input ports from the operation in flight
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NX; i++) x_s[i] <= x_prior[i*N +: N];
            for (int j = 0; j < NZ; j++) begin
                zm_s[j] <= z_meas[j*N +: N];
                zh_s[j] <= z_hat[j*N +: N];
            end
            for (int i = 0; i < NX; i++)
                for (int j = 0; j < NZ; j++)
                    k_s[i][j] <= k[(i*NZ+j)*N +: N];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_i    <= '0;
            cnt_j    <= '0;
            acc      <= '0;
            sat_st   <= 1'b0;
            done     <= 1'b0;
            sat_flag <= 1'b0;
            x_post   <= '0;
            for (int i = 0; i < NX; i++) res_r[i] <= '0;
            for (int j = 0; j < NZ; j++) y_r[j] <= '0;
        end else begin
            done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    cnt_i <= '0;
                    cnt_j <= '0;
                end
                S_INNOV: begin
                    y_r[cnt_j] <= y_sat;
                    if (y_ovf) sat_st <= 1'b1;
                    cnt_j <= j_last ? '0 : cnt_j + JW'(1);
                end
                S_MAC: begin
                    acc   <= acc_nxt;
                    cnt_j <= j_last ? '0 : cnt_j + JW'(1);
                    if (j_last) begin
                        res_r[cnt_i] <= sum_sat;
                        if (sum_ovf) sat_st <= 1'b1;
                        cnt_i <= i_last ? '0 : cnt_i + IW'(1);
                    end
                end
                S_DONE: begin
                    for (int i = 0; i < NX; i++) x_post[i*N +: N] <= res_r[i];
                    sat_flag <= sat_st;
                    sat_st   <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_kf_post_state_mac.sv
// tb/tb_kf_post_state_mac.sv - self-checking bench: 2x2 vector table and protocol cases, 4x3 random scoreboard
module tb_kf_post_state_mac;
    localparam int LAT_A = 2 + 2*2 + 1;
    localparam int LAT_B = 3 + 4*3 + 1;
    localparam int S = 65536;
    localparam int H = 32768;
`ifdef KF_POST_ROUND_EN
    localparam int RP = 1;
    localparam int RN = 0;
`else
    localparam int RP = 0;
    localparam int RN = -1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         a_start, a_busy, a_done, a_sat;
    logic [63:0]  a_x, a_zm, a_zh, a_xp;
    logic [127:0] a_k;
    logic         b_start, b_busy, b_done, b_sat;
    logic [127:0] b_x, b_xp;
    logic [95:0]  b_zm, b_zh;
    logic [383:0] b_k;

    kf_post_state_mac #(.N(32), .FRAC(16), .NX(2), .NZ(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .x_prior(a_x), .z_meas(a_zm), .z_hat(a_zh),
        .k(a_k), .busy(a_busy), .done(a_done), .x_post(a_xp), .sat_flag(a_sat));

    kf_post_state_mac #(.N(32), .FRAC(16), .NX(4), .NZ(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .x_prior(b_x), .z_meas(b_zm), .z_hat(b_zh),
        .k(b_k), .busy(b_busy), .done(b_done), .x_post(b_xp), .sat_flag(b_sat));

    logic [63:0]  a_obs_x   [64];
    logic         a_obs_sat [64];
    int           a_obs_cyc [64];
    int           a_obs_cnt = 0;
    logic [127:0] b_obs_x   [64];
    logic         b_obs_sat [64];
    int           b_obs_cyc [64];
    int           b_obs_cnt = 0;

    always @(negedge clk) begin
        if (a_done) begin
            a_obs_x[a_obs_cnt[5:0]]   <= a_xp;
            a_obs_sat[a_obs_cnt[5:0]] <= a_sat;
            a_obs_cyc[a_obs_cnt[5:0]] <= cyc;
            a_obs_cnt <= a_obs_cnt + 1;
        end
        if (b_done) begin
            b_obs_x[b_obs_cnt[5:0]]   <= b_xp;
            b_obs_sat[b_obs_cnt[5:0]] <= b_sat;
            b_obs_cyc[b_obs_cnt[5:0]] <= cyc;
            b_obs_cnt <= b_obs_cnt + 1;
        end
    end

    typedef struct {
        logic [63:0]  x, zm, zh;
        logic [127:0] k;
        logic [63:0]  ex;
        logic         es;
    } a_vec_t;

    typedef struct packed { logic [63:0] x; logic sat; int t0; } a_exp_t;
    typedef struct packed { logic [127:0] x; int t0; } b_exp_t;

    a_exp_t a_q[$];
    b_exp_t b_q[$];
    a_vec_t tbl[10];
    int     checks = 0;
    int     failures = 0;
    int     a_rd = 0;
    int     b_rd = 0;

    function automatic logic [63:0] p2(input int e0, input int e1);
        return {e1, e0};
    endfunction

    function automatic logic [127:0] pk(input int k00, input int k01, input int k10, input int k11);
        return {k11, k10, k01, k00};
    endfunction

    task automatic check(input string nm, input int idx, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0d expected=%0d", nm, idx, act, exp);
        end
    endtask

    task automatic check_tol(input string nm, input int idx, input longint act, input longint exp);
        longint d;
        d = act - exp;
        checks++;
        if (d > 1 || d < -1) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0d expected=%0d (+/-1)", nm, idx, act, exp);
        end
    endtask

    task automatic a_launch(input a_vec_t v);
        a_exp_t e;
        a_x = v.x; a_zm = v.zm; a_zh = v.zh; a_k = v.k;
        a_start = 1'b1;
        @(posedge clk);
        #1;
        e.x = v.ex; e.sat = v.es; e.t0 = cyc;
        a_q.push_back(e);
        a_start = 1'b0;
        a_x  = {$urandom, $urandom};
        a_zm = {$urandom, $urandom};
        a_zh = {$urandom, $urandom};
        a_k  = {$urandom, $urandom, $urandom, $urandom};
        check("a_busy_after_accept", a_q.size(), longint'(a_busy), 1);
    endtask

    task automatic a_wait_check(input int idx);
        a_exp_t e;
        int     n;
        n = 0;
        while (a_obs_cnt <= a_rd && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        e = a_q.pop_front();
        if (a_obs_cnt <= a_rd) begin
            checks++;
            failures++;
            $display("FAIL a_done_timeout[%0d] actual=no_done expected=done", idx);
        end else begin
            check("a_busy_in_done", idx, longint'(a_busy), 1);
            check("a_x0", idx, longint'($signed(a_obs_x[a_rd[5:0]][31:0])), longint'($signed(e.x[31:0])));
            check("a_x1", idx, longint'($signed(a_obs_x[a_rd[5:0]][63:32])), longint'($signed(e.x[63:32])));
            check("a_sat", idx, longint'(a_obs_sat[a_rd[5:0]]), longint'(e.sat));
            check("a_lat", idx, longint'(a_obs_cyc[a_rd[5:0]] - e.t0), LAT_A);
            a_rd++;
        end
    endtask

    task automatic b_launch();
        int     xv [4];
        int     yv [3];
        int     kv [4][3];
        longint acc;
        b_exp_t e;
        for (int j = 0; j < 3; j++) begin
            int zm, zh;
            zm = int'($urandom_range(524288)) - 262144;
            zh = int'($urandom_range(524288)) - 262144;
            b_zm[j*32 +: 32] = zm;
            b_zh[j*32 +: 32] = zh;
            yv[j] = zm - zh;
        end
        for (int i = 0; i < 4; i++) begin
            xv[i] = int'($urandom_range(524288)) - 262144;
            b_x[i*32 +: 32] = xv[i];
            for (int j = 0; j < 3; j++) begin
                kv[i][j] = int'($urandom_range(524288)) - 262144;
                b_k[(i*3+j)*32 +: 32] = kv[i][j];
            end
        end
        for (int i = 0; i < 4; i++) begin
            acc = 0;
            for (int j = 0; j < 3; j++) acc += longint'(kv[i][j]) * longint'(yv[j]);
            e.x[i*32 +: 32] = 32'(longint'(xv[i]) + (acc >>> 16));
        end
        b_start = 1'b1;
        @(posedge clk);
        #1;
        e.t0 = cyc;
        b_q.push_back(e);
        b_start = 1'b0;
        b_x = {4{$urandom}};
    endtask

    task automatic b_wait_check(input int idx);
        b_exp_t e;
        int     n;
        n = 0;
        while (b_obs_cnt <= b_rd && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        e = b_q.pop_front();
        if (b_obs_cnt <= b_rd) begin
            checks++;
            failures++;
            $display("FAIL b_done_timeout[%0d] actual=no_done expected=done", idx);
        end else begin
            for (int i = 0; i < 4; i++)
                check_tol("b_x", idx*4+i, longint'($signed(b_obs_x[b_rd[5:0]][i*32 +: 32])),
                          longint'($signed(e.x[i*32 +: 32])));
            check("b_sat", idx, longint'(b_obs_sat[b_rd[5:0]]), 0);
            check("b_lat", idx, longint'(b_obs_cyc[b_rd[5:0]] - e.t0), LAT_B);
            b_rd++;
        end
    endtask

    initial begin
        tbl[0] = '{p2(S, -H), p2(2*S, S), p2(S, -H), pk(H, 0, 0, H), p2(98304, 16384), 1'b0};
        tbl[1] = '{p2(S, -H), p2(2*S, S), p2(S, -H), pk(H, 16384, 0, S), p2(122880, 65536), 1'b0};
        tbl[2] = '{p2(32'h7FFFFFFF, 0), p2(S, 0), p2(0, 0), pk(S, 0, 0, 0), p2(32'h7FFFFFFF, 0), 1'b1};
        tbl[3] = '{p2(32'h80000001, 6), p2(32'h7FFFFFFF, 0), p2(32'h80000000, 0), pk(S, 0, 0, 0), p2(0, 6), 1'b1};
        tbl[4] = '{p2(S, -H), p2(2*S, S), p2(S, -H), pk(H, 0, 0, H), p2(98304, 16384), 1'b0};
        tbl[5] = '{p2(32'h80000000, 0), p2(0, 0), p2(S, 0), pk(S, 0, 0, 0), p2(32'h80000000, 0), 1'b1};
        tbl[6] = '{p2(0, 0), p2(H, 0), p2(0, 0), pk(1, 0, 0, 0), p2(RP, 0), 1'b0};
        tbl[7] = '{p2(0, 0), p2(-H, 0), p2(0, 0), pk(1, 0, 0, 0), p2(RN, 0), 1'b0};
        tbl[8] = '{p2(0, 0), p2(-H-1, 0), p2(0, 0), pk(1, 0, 0, 0), p2(-1, 0), 1'b0};
        tbl[9] = '{p2(0, 0), p2(H-1, 0), p2(0, 0), pk(1, 0, 0, 0), p2(0, 0), 1'b0};

        rst_n = 1'b0;
        a_start = 1'b0; a_x = '0; a_zm = '0; a_zh = '0; a_k = '0;
        b_start = 1'b0; b_x = '0; b_zm = '0; b_zh = '0; b_k = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("a_rst_busy", 0, longint'(a_busy), 0);
        check("a_rst_done", 0, longint'(a_done), 0);
        check("a_rst_xpost", 0, longint'(a_xp != '0), 0);
        check("a_rst_sat", 0, longint'(a_sat), 0);
        check("b_rst_busy", 0, longint'(b_busy), 0);
        check("b_rst_xpost", 0, longint'(b_xp != '0), 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // each entry is launched in the done cycle of the previous one, exercising back-to-back accept
        for (int t = 0; t < 10; t++) begin
            a_launch(tbl[t]);
            a_wait_check(t);
        end

        repeat (3) @(negedge clk);
        #1;
        a_launch(tbl[1]);
        repeat (4) @(negedge clk);
        #1;
        a_x = tbl[0].x; a_zm = tbl[0].zm; a_zh = tbl[0].zh; a_k = tbl[0].k;
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        a_wait_check(20);
        repeat (20) @(negedge clk);
        #1;
        check("a_single_done", 20, longint'(a_obs_cnt), longint'(a_rd));

        a_launch(tbl[0]);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("a_abort_busy", 21, longint'(a_busy), 0);
        check("a_abort_xpost", 21, longint'(a_xp != '0), 0);
        check("a_abort_sat", 21, longint'(a_sat), 0);
        rst_n = 1'b1;
        void'(a_q.pop_front());
        repeat (20) @(negedge clk);
        #1;
        check("a_no_done_after_abort", 21, longint'(a_obs_cnt), longint'(a_rd));
        a_launch(tbl[1]);
        a_wait_check(22);

        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            #1;
            b_launch();
            b_wait_check(t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
